// File: rtl/q1_seq_detector.sv
// Moore detector for the serial pattern 1-0-1-1 with overlap; y is a registered
// flag that is high exactly while the FSM sits in the match state.
//
// state | meaning
// S0    | idle, no useful prefix
// S1    | seen "1"
// S2    | seen "10"
// S3    | seen "101"
// S4    | seen "1011", match (y = 1)
module q1_seq_detector (
    input  logic clk,
    input  logic reset_n,
    input  logic x,
    output logic y
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_t;

    state_t state;
    state_t state_nx;

    always_comb begin
        state_nx = S0;
        case (state)
            S0:      state_nx = x ? S1 : S0;
            S1:      state_nx = x ? S1 : S2;
            S2:      state_nx = x ? S3 : S0;
            S3:      state_nx = x ? S4 : S2;
            S4:      state_nx = x ? S1 : S2;
            default: state_nx = S0;
        endcase
    end

    // reset_n is active-high despite its name; y tracks the next state so it
    // always equals (state == S4) without a combinational path from x.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= S0;
            y     <= 1'b0;
        end else begin
            state <= state_nx;
            y     <= (state_nx == S4);
        end
    end

endmodule

// File: tb/tb_q1_seq_detector.sv
// Scoreboard bench for q1_seq_detector: stimulus queues hand-computed {state,y}
// per bit, a monitor pops and compares one entry per sampled clock edge.
module tb_q1_seq_detector;

    logic clk;
    logic reset_n;
    logic x;
    logic y;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] exp_q[$];

    q1_seq_detector dut (
        .clk     (clk),
        .reset_n (reset_n),
        .x       (x),
        .y       (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One bit per falling edge; the DUT samples it on the next rising edge.
    task automatic run(input string name, input string bits, input string sts, input string ys);
        for (int i = 0; i < bits.len(); i++) begin
            @(negedge clk);
            x = (bits[i] == "1");
            exp_q.push_back({3'(sts[i] - 8'd48), ys[i] == "1"});
        end
    endtask

    // Monitor: one scoreboard entry is retired per sampled edge.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state", 3'(dut.state), e[3:1]);
                check("y", {2'b00, y}, {2'b00, e[0]});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cyc;
        reset_n = 1'b1;
        x       = 1'b0;
        #2;
        check("reset_state_pre_clk", 3'(dut.state), 3'd0);
        check("reset_y_pre_clk", {2'b00, y}, 3'd0);
        #10;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("release_hold_s0", 3'(dut.state), 3'd0);

        run("zeros",      "0000",    "0000",    "0000");
        run("ones",       "11111",   "11111",   "00000");
        run("overlap",    "010111",  "232341",  "000010");
        run("to_s0",      "00",      "20",      "00");
        run("redetect",   "1011011", "1234234", "0001001");
        run("to_s0b",     "00",      "20",      "00");
        run("near_miss1", "10011",   "12011",   "00000");
        run("near_miss2", "1100",    "1120",    "0000");
        run("reach_s3",   "101",     "123",     "000");

        @(posedge clk);
        #3;
        reset_n = 1'b1;
        #1;
        check("async_rst_state", 3'(dut.state), 3'd0);
        check("async_rst_y", {2'b00, y}, 3'd0);
        reset_n = 1'b0;

        run("single_one", "1",    "1",    "0");
        run("match_again", "011", "234",  "001");

        @(posedge clk);
        #3;
        check("pre_rst_y_high", {2'b00, y}, 3'd1);
        reset_n = 1'b1;
        #1;
        check("async_rst_y_drop", {2'b00, y}, 3'd0);
        check("async_rst_state2", 3'(dut.state), 3'd0);
        reset_n = 1'b0;

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        check("scoreboard_drained", 3'(exp_q.size() > 0 ? 1 : 0), 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/q1_seq_detector.md
Name: q1_seq_detector

Overview:
- Moore finite-state machine that watches a 1-bit serial input `x`, sampled once per clock.
- Asserts `y` for exactly one clock cycle each time the most recent four samples form the pattern 1-0-1-1.
- Detection is overlapping: the tail of one match can start the next match.
- Used as a small standalone control/pattern-recognition block; output is registered-state derived (Moore), so `y` has no combinational path from `x`.

Parameters:
- None. Pattern (1011) and state encoding are fixed.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset_n`  input  1  asynchronous, active-high reset. Despite the suffix, the block is in reset while `reset_n` = 1 and runs while `reset_n` = 0.
- `x`  input  1  serial data bit, sampled on rising edge of `clk`.
- `y`  output  1  detect flag, high for one cycle after 1011 has been received.

Behaviour:
- Internal 3-bit register `state`, visible hierarchically as `state` for debug and monitoring.
- Encoding:
  - S0 = 000: idle, no useful prefix.
  - S1 = 001: seen "1".
  - S2 = 010: seen "10".
  - S3 = 011: seen "101".
  - S4 = 100: seen "1011", match.
- Reset:
  - While `reset_n` = 1, `state` is forced to S0 asynchronously (no clock required) and `y` = 0.
  - Release is synchronous in effect: the first sample is taken on the first rising edge after `reset_n` falls to 0.
  - Reset asserted mid-sequence discards any partial match immediately; `y` drops at once if it was high.
- Transitions on rising edge of `clk` (next state for x=0 / x=1):
  - S0: 0 -> S0, 1 -> S1
  - S1: 0 -> S2, 1 -> S1
  - S2: 0 -> S0, 1 -> S3
  - S3: 0 -> S2, 1 -> S4
  - S4: 0 -> S2, 1 -> S1 (overlap: the trailing "1" of 1011 restarts the prefix)
- Unused encodings 101, 110 and 111 go to S0 on the next edge; `y` = 0 in those states.
- Output:
  - `y` = 1 if and only if `state` == S4; purely a function of `state`.
  - Latency: `y` rises on the same rising edge that samples the final '1' of 1011, and stays high for exactly one clock period.
  - Back-to-back matches are impossible in consecutive cycles; the minimum spacing between `y` pulses is 3 cycles (e.g. 1011011 gives two pulses).
- Long runs:
  - A run of consecutive 1s holds S1 and never asserts `y`.
  - A run of 0s returns to or holds S0.
- Input timing: `x` must be stable around the rising edge of `clk`. Stimulus driven immediately after a rising edge is sampled on the following edge.

Test Plan:
- Reset: hold `reset_n`=1 for 12 ns with `x`=0 -> `state`=000 and `y`=0 before any clock edge. Release `reset_n` to 0 -> stays S0 while `x`=0.
- Zeros and ones: feed 0,0,0,0, then 1,1,1,1,1 -> `state` S0 throughout the zeros, then S1 held for the whole run of 1s. `y` stays 0.
- Overlapping match: continue with 0,1,0,1,1,1 -> states S2,S3,S2,S3,S4,S1. `y`=1 only for the cycle in S4, then 0.
- Overlap re-detect: from S0 feed 1,0,1,1,0,1,1 -> `y` pulses after the 4th bit and after the 7th bit. Two one-cycle pulses, 3 cycles apart.
- Near-miss patterns: feed 1,0,0,1,1 and 1,1,0,0 -> `y` never asserts. 100 returns to S0.
- Asynchronous reset mid-operation: reach S3 (1,0,1), then pulse `reset_n`=1 between clock edges -> `state`=S0 immediately. A subsequent single 1 does not produce `y`.
